multicycle_control: RTL and testbench

- Parametrised successor to the single-cycle control decoder.
- Sequences each instruction through IDLE/FETCH/DECODE/EXEC/MEM/WB/HALT and issues datapath strobes per state.
- Owns the instruction-memory and data-memory request/ready handshake, with a wait-state timeout.
- Sits between the IR/opcode field and the datapath (PC, register file, ALU, memory port).

---
 rtl/ctrl_pkg.sv | 51 +++++
 rtl/ctrl_opdecode.sv | 39 +++
 rtl/multicycle_control.sv | 175 +++++++++++++++++
 tb/tb_multicycle_control.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - Opcode map, state, ALU-op and instruction-class encodings shared by the control unit.
package ctrl_pkg;

    localparam logic [3:0] OP_HALT  = 4'b0000;
    localparam logic [3:0] OP_JMP   = 4'b0001;
    localparam logic [3:0] OP_BGT   = 4'b0100;
    localparam logic [3:0] OP_BLT   = 4'b0101;
    localparam logic [3:0] OP_BEQ   = 4'b0110;
    localparam logic [3:0] OP_ANDI  = 4'b1000;
    localparam logic [3:0] OP_ORI   = 4'b1001;
    localparam logic [3:0] OP_LBU   = 4'b1010;
    localparam logic [3:0] OP_SB    = 4'b1011;
    localparam logic [3:0] OP_LB    = 4'b1100;
    localparam logic [3:0] OP_SW    = 4'b1101;
    localparam logic [3:0] OP_TYPEA = 4'b1111;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_OR  = 2'b10;
    localparam logic [1:0] ALU_AND = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE, ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_HALT
    } state_t;

    typedef enum logic [2:0] {
        CLS_ILLEGAL, CLS_HALT, CLS_ALU_R, CLS_ALU_I,
        CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JUMP
    } cls_t;

    // hi_zero: every opcode bit above the 4-bit map is zero.
    function automatic cls_t op_class(input logic [3:0] op, input logic hi_zero);
        cls_t c;
        if (!hi_zero) begin
            c = CLS_ILLEGAL;
        end else begin
            case (op)
                OP_HALT:                 c = CLS_HALT;
                OP_TYPEA:                c = CLS_ALU_R;
                OP_ANDI, OP_ORI:         c = CLS_ALU_I;
                OP_LBU, OP_LB:           c = CLS_LOAD;
                OP_SB, OP_SW:            c = CLS_STORE;
                OP_BGT, OP_BLT, OP_BEQ:  c = CLS_BRANCH;
                OP_JMP:                  c = CLS_JUMP;
                default:                 c = CLS_ILLEGAL;
            endcase
        end
        return c;
    endfunction

endpackage

// File: rtl/ctrl_opdecode.sv
// rtl/ctrl_opdecode.sv - Combinational opcode decoder: latched opcode to class and datapath controls.
module ctrl_opdecode
    import ctrl_pkg::*;
#(
    parameter int OP_W = 4
) (
    input  logic [OP_W-1:0] op,
    output cls_t            cls,
    output logic [1:0]      alu_op,
    output logic            alu_src,
    output logic            byte_op,
    output logic            mem_unsigned,
    output logic            legal
);

    always_comb begin
        cls          = op_class(op[3:0], (op >> 4) == '0);
        legal        = (cls != CLS_ILLEGAL);
        alu_op       = ALU_ADD;
        alu_src      = 1'b0;
        byte_op      = 1'b0;
        mem_unsigned = 1'b0;
        case (cls)
            CLS_ALU_R: alu_op = ALU_AND;
            CLS_ALU_I: begin
                alu_src = 1'b1;
                alu_op  = (op[3:0] == OP_ORI) ? ALU_OR : ALU_AND;
            end
            CLS_LOAD, CLS_STORE: begin
                alu_src      = 1'b1;
                byte_op      = (op[3:0] == OP_LBU) || (op[3:0] == OP_LB) || (op[3:0] == OP_SB);
                mem_unsigned = (op[3:0] == OP_LBU);
            end
            CLS_BRANCH: alu_op = ALU_SUB;
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - Multicycle control FSM: per-state datapath strobes and memory handshake with timeout.
module multicycle_control
    import ctrl_pkg::*;
#(
    parameter int OP_W        = 4,
    parameter int ALUOP_W     = 2,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [OP_W-1:0]    opcode,
    input  logic               mem_ready,
    input  logic               cmp_true,
    output logic               mem_read,
    output logic               mem_write,
    output logic               mem_unsigned,
    output logic               byte_op,
    output logic               ir_write,
    output logic               pc_write,
    output logic               branch,
    output logic               alu_src,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               mem_to_reg,
    output logic               reg_write,
    output logic               r15_write,
    output logic               halted,
    output logic               illegal_op,
    output logic               bus_err
);

    localparam int              CNT_W    = $clog2(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic              bus_err_q, bus_err_d;
    logic              illegal_q, illegal_d;

    cls_t              dq_cls;
    logic [1:0]        dq_alu_op;
    logic              dq_alu_src, dq_byte_op, dq_mem_unsigned, dq_legal;
    cls_t              in_cls;
    logic [1:0]        alu_op_c;
    logic              is_load;

    ctrl_opdecode #(.OP_W(OP_W)) u_opdecode (
        .op           (op_q),
        .cls          (dq_cls),
        .alu_op       (dq_alu_op),
        .alu_src      (dq_alu_src),
        .byte_op      (dq_byte_op),
        .mem_unsigned (dq_mem_unsigned),
        .legal        (dq_legal)
    );

    // Only next-state and the registered illegal flag look at the live opcode.
    assign in_cls     = op_class(opcode[3:0], (opcode >> 4) == '0);
    assign is_load    = (dq_cls == CLS_LOAD);
    assign alu_op     = ALUOP_W'(alu_op_c);
    assign bus_err    = bus_err_q;
    assign illegal_op = illegal_q;
    assign halted     = (state_q == ST_HALT);

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        wait_cnt_d   = '0;
        bus_err_d    = bus_err_q;
        illegal_d    = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_unsigned = 1'b0;
        byte_op      = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        branch       = 1'b0;
        alu_src      = 1'b0;
        alu_op_c     = ALU_ADD;
        mem_to_reg   = 1'b0;
        reg_write    = 1'b0;
        r15_write    = 1'b0;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_FETCH;
            ST_FETCH: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = ST_DECODE;
                end else if (wait_cnt_q == CNT_LAST) begin
                    state_d   = ST_HALT;
                    bus_err_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            ST_DECODE: begin
                op_d = opcode;
                case (in_cls)
                    CLS_HALT:    state_d = ST_HALT;
                    CLS_ILLEGAL: begin
                        state_d   = ST_FETCH;
                        illegal_d = 1'b1;
                    end
                    default:     state_d = ST_EXEC;
                endcase
            end
            ST_EXEC: begin
                state_d = ST_FETCH;
                if (dq_legal) begin
                    alu_src  = dq_alu_src;
                    alu_op_c = dq_alu_op;
                    case (dq_cls)
                        CLS_ALU_R, CLS_ALU_I: state_d = ST_WB;
                        CLS_LOAD, CLS_STORE:  state_d = ST_MEM;
                        CLS_BRANCH: begin
                            branch    = 1'b1;
                            pc_write  = cmp_true;
                            r15_write = 1'b1;
                        end
                        CLS_JUMP: begin
                            branch   = 1'b1;
                            pc_write = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            ST_MEM: begin
                mem_read     = is_load;
                mem_write    = !is_load;
                byte_op      = dq_byte_op;
                mem_unsigned = dq_mem_unsigned;
                if (mem_ready) begin
                    state_d = is_load ? ST_WB : ST_FETCH;
                end else if (wait_cnt_q == CNT_LAST) begin
                    state_d   = ST_HALT;
                    bus_err_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            ST_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = is_load;
                r15_write  = (dq_cls == CLS_ALU_R);
                state_d    = ST_FETCH;
            end
            ST_HALT: if (start) begin
                state_d   = ST_FETCH;
                bus_err_d = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            op_q       <= '0;
            wait_cnt_q <= '0;
            bus_err_q  <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            wait_cnt_q <= wait_cnt_d;
            bus_err_q  <= bus_err_d;
            illegal_q  <= illegal_d;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - Self-checking bench: per-instruction cycle model versus multicycle_control.
module tb_multicycle_control;

    localparam int OP_W = 5;

    localparam logic [15:0] MR  = 16'h8000, MW  = 16'h4000, MU  = 16'h2000, BO  = 16'h1000;
    localparam logic [15:0] IRW = 16'h0800, PCW = 16'h0400, BR  = 16'h0200, AS  = 16'h0100;
    localparam logic [15:0] M2R = 16'h0020, RW  = 16'h0010, R15 = 16'h0008, HLT = 16'h0004;
    localparam logic [15:0] IL  = 16'h0002, BE  = 16'h0001;

    localparam logic [OP_W-1:0] O_JMP = 5'h01, O_BEQ = 5'h06, O_ORI = 5'h09;
    localparam logic [OP_W-1:0] O_LBU = 5'h0A, O_SW  = 5'h0D, O_BAD = 5'h03;

    localparam int K_ILL = 0, K_ALU = 1, K_LD = 2, K_ST = 3, K_BR = 4, K_JMP = 5, K_HALT = 6;

    logic clk = 1'b0;
    logic rst_n, start, mem_ready, cmp_true;
    logic [OP_W-1:0] opcode;
    logic mem_read, mem_write, mem_unsigned, byte_op, ir_write, pc_write, branch, alu_src;
    logic [1:0] alu_op;
    logic mem_to_reg, reg_write, r15_write, halted, illegal_op, bus_err;
    logic [15:0] outs;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0]     exp;
        logic            rdy;
        logic            cmp;
        logic            st;
        logic [OP_W-1:0] opc;
    } cyc_t;

    cyc_t q[$];
    logic m_illegal = 1'b0;
    logic m_bus_err = 1'b0;

    always #5 clk = ~clk;

    multicycle_control #(.OP_W(OP_W), .ALUOP_W(2), .MEM_TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode),
        .mem_ready(mem_ready), .cmp_true(cmp_true),
        .mem_read(mem_read), .mem_write(mem_write), .mem_unsigned(mem_unsigned),
        .byte_op(byte_op), .ir_write(ir_write), .pc_write(pc_write), .branch(branch),
        .alu_src(alu_src), .alu_op(alu_op), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .r15_write(r15_write), .halted(halted), .illegal_op(illegal_op), .bus_err(bus_err)
    );

    assign outs = {mem_read, mem_write, mem_unsigned, byte_op, ir_write, pc_write, branch,
                   alu_src, alu_op, mem_to_reg, reg_write, r15_write, halted, illegal_op, bus_err};

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic logic [OP_W-1:0] rop();
        return OP_W'($urandom);
    endfunction

    function automatic logic [15:0] aop(input logic [1:0] x);
        return {8'h00, x, 6'h00};
    endfunction

    function automatic int kind_of(input logic [OP_W-1:0] op);
        logic [3:0] lo;
        lo = op[3:0];
        if (op[OP_W-1:4] != '0) return K_ILL;
        case (lo)
            4'h0:                    return K_HALT;
            4'hF, 4'h8, 4'h9:        return K_ALU;
            4'hA, 4'hC:              return K_LD;
            4'hB, 4'hD:              return K_ST;
            4'h4, 4'h5, 4'h6:        return K_BR;
            4'h1:                    return K_JMP;
            default:                 return K_ILL;
        endcase
    endfunction

    task automatic push(input logic [15:0] e, input logic rdy, input logic cmp,
                        input logic st, input logic [OP_W-1:0] opc);
        cyc_t c;
        if (m_illegal) begin
            e = e | IL;
            m_illegal = 1'b0;
        end
        if (m_bus_err) e = e | BE;
        c.exp = e; c.rdy = rdy; c.cmp = cmp; c.st = st; c.opc = opc;
        q.push_back(c);
    endtask

    task automatic fetch(input int fw);
        for (int i = 0; i < fw; i++) push(MR, 1'b0, rb(), rb(), rop());
        push(MR | IRW | PCW, 1'b1, rb(), rb(), rop());
    endtask

    // Expected cycles of one instruction from fetch to its last state.
    task automatic build_instr(input logic [OP_W-1:0] op, input int fw, input int mw, input logic cmp);
        int k;
        logic [15:0] acc;
        k = kind_of(op);
        fetch(fw);
        push(16'h0, rb(), rb(), rb(), op);
        case (k)
            K_ILL: m_illegal = 1'b1;
            K_ALU: begin
                if (op[3:0] == 4'hF)      push(aop(2'b11), rb(), rb(), rb(), rop());
                else if (op[3:0] == 4'h9) push(AS | aop(2'b10), rb(), rb(), rb(), rop());
                else                      push(AS | aop(2'b11), rb(), rb(), rb(), rop());
                push(RW | ((op[3:0] == 4'hF) ? R15 : 16'h0), rb(), rb(), rb(), rop());
            end
            K_LD, K_ST: begin
                push(AS, rb(), rb(), rb(), rop());
                if (k == K_LD) acc = MR | BO | ((op[3:0] == 4'hA) ? MU : 16'h0);
                else           acc = MW | ((op[3:0] == 4'hB) ? BO : 16'h0);
                for (int i = 0; i < mw; i++) push(acc, 1'b0, rb(), rb(), rop());
                push(acc, 1'b1, rb(), rb(), rop());
                if (k == K_LD) push(RW | M2R, rb(), rb(), rb(), rop());
            end
            K_BR:  push(BR | R15 | aop(2'b01) | (cmp ? PCW : 16'h0), rb(), cmp, rb(), rop());
            K_JMP: push(BR | PCW, rb(), rb(), rb(), rop());
            default: ;
        endcase
    endtask

    task automatic drive(input cyc_t c);
        @(posedge clk);
        #1;
        start = c.st; opcode = c.opc; mem_ready = c.rdy; cmp_true = c.cmp;
        @(negedge clk);
    endtask

    task automatic test_reset();
        cyc_t c;
        int n = 0;
        rst_n = 1'b0; start = 1'b0; opcode = rop(); mem_ready = 1'b1; cmp_true = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (outs !== 16'h0) begin
            errors++;
            $display("FAIL reset_hold: outs=%h expected %h", outs, 16'h0);
        end
        #2 rst_n = 1'b1;
        repeat (2) push(16'h0, rb(), rb(), 1'b0, rop());
        push(16'h0, rb(), rb(), 1'b1, rop());
        while (q.size() > 0) begin
            c = q.pop_front(); drive(c); checks++; n++;
            if (outs !== c.exp) begin
                errors++;
                $display("FAIL reset_idle cyc%0d: outs=%h expected %h", n, outs, c.exp);
            end
        end
    endtask

    task automatic test_ori();
        cyc_t c;
        int n = 0;
        build_instr(O_ORI, 0, 0, 1'b0);
        build_instr(O_ORI, 15, 0, 1'b0);
        while (q.size() > 0) begin
            c = q.pop_front(); drive(c); checks++; n++;
            if (outs !== c.exp) begin
                errors++;
                $display("FAIL ori cyc%0d: outs=%h expected %h", n, outs, c.exp);
            end
        end
    endtask

    task automatic test_lbu();
        cyc_t c;
        int n = 0;
        build_instr(O_LBU, 0, 3, 1'b0);
        while (q.size() > 0) begin
            c = q.pop_front(); drive(c); checks++; n++;
            if (outs !== c.exp) begin
                errors++;
                $display("FAIL lbu cyc%0d: outs=%h expected %h", n, outs, c.exp);
            end
        end
    endtask

    task automatic test_beq();
        cyc_t c;
        int n = 0;
        build_instr(O_BEQ, 0, 0, 1'b0);
        build_instr(O_BEQ, 1, 0, 1'b1);
        while (q.size() > 0) begin
            c = q.pop_front(); drive(c); checks++; n++;
            if (outs !== c.exp) begin
                errors++;
                $display("FAIL beq cyc%0d: outs=%h expected %h", n, outs, c.exp);
            end
        end
    endtask

    task automatic test_illegal();
        cyc_t c;
        int n = 0;
        build_instr(O_BAD, 0, 0, 1'b0);
        build_instr(5'h13, 0, 0, 1'b0);
        build_instr(O_ORI, 0, 0, 1'b0);
        while (q.size() > 0) begin
            c = q.pop_front(); drive(c); checks++; n++;
            if (outs !== c.exp) begin
                errors++;
                $display("FAIL illegal cyc%0d: outs=%h expected %h", n, outs, c.exp);
            end
        end
    endtask

    task automatic test_halt_op();
        cyc_t c;
        int n = 0;
        fetch(0);
        push(16'h0, rb(), rb(), rb(), 5'h00);
        repeat (2) push(HLT, rb(), rb(), 1'b0, rop());
        push(HLT, rb(), rb(), 1'b1, rop());
        build_instr(O_JMP, 0, 0, 1'b0);
        while (q.size() > 0) begin
            c = q.pop_front(); drive(c); checks++; n++;
            if (outs !== c.exp) begin
                errors++;
                $display("FAIL halt_op cyc%0d: outs=%h expected %h", n, outs, c.exp);
            end
        end
    endtask

    task automatic test_timeout();
        cyc_t c;
        int n = 0;
        repeat (16) push(MR, 1'b0, rb(), rb(), rop());
        m_bus_err = 1'b1;
        repeat (2) push(HLT, rb(), rb(), 1'b0, rop());
        push(HLT, rb(), rb(), 1'b1, rop());
        m_bus_err = 1'b0;
        build_instr(O_ORI, 0, 0, 1'b0);
        while (q.size() > 0) begin
            c = q.pop_front(); drive(c); checks++; n++;
            if (outs !== c.exp) begin
                errors++;
                $display("FAIL timeout cyc%0d: outs=%h expected %h", n, outs, c.exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        cyc_t c;
        int n = 0;
        logic [OP_W-1:0] op;
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 7) == 0) op = OP_W'($urandom_range(16, 31));
            else                           op = OP_W'($urandom_range(1, 15));
            build_instr(op, ($urandom_range(0, 5) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 2),
                        $urandom_range(0, 15), rb());
        end
        while (q.size() > 0) begin
            c = q.pop_front(); drive(c); checks++; n++;
            if (outs !== c.exp) begin
                errors++;
                $display("FAIL random cyc%0d: outs=%h expected %h", n, outs, c.exp);
            end
        end
    endtask

    task automatic test_async_reset();
        cyc_t c;
        int n = 0;
        build_instr(O_SW, 0, 5, 1'b0);
        repeat (5) begin
            c = q.pop_front(); drive(c); checks++; n++;
            if (outs !== c.exp) begin
                errors++;
                $display("FAIL async_pre cyc%0d: outs=%h expected %h", n, outs, c.exp);
            end
        end
        q.delete();
        #2 rst_n = 1'b0;
        start = 1'b0;
        #1;
        checks++;
        if (outs !== 16'h0) begin
            errors++;
            $display("FAIL async_drop: outs=%h expected %h", outs, 16'h0);
        end
        m_illegal = 1'b0;
        m_bus_err = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (3) push(16'h0, rb(), rb(), 1'b0, rop());
        push(16'h0, rb(), rb(), 1'b1, rop());
        build_instr(O_ORI, 0, 0, 1'b0);
        n = 0;
        while (q.size() > 0) begin
            c = q.pop_front(); drive(c); checks++; n++;
            if (outs !== c.exp) begin
                errors++;
                $display("FAIL async_post cyc%0d: outs=%h expected %h", n, outs, c.exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ori();
        test_lbu();
        test_beq();
        test_illegal();
        test_halt_op();
        test_timeout();
        test_back_to_back();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
